stack_bus_master: RTL and testbench

STACK_BUS_MASTER -- requirements
Module: stack_bus_master

---
 rtl/stack_bus_master.sv | 168 ++++++++++++++++
 tb/tb_stack_bus_master.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/stack_bus_master.sv
// ----------------------------------------------------------------------------
// stack_bus_master
//
// Turns single commands into strobed bus cycles on a small memory-mapped
// register block at 0xFC00..0xFC03. Each accepted command runs through
// IDLE -> SETUP -> STROBE -> HOLD and returns to IDLE. That is four clocks
// including the accept cycle. Every bus-facing output is registered.
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   rst        : asynchronous active-high reset
//   cmd_valid  : command request
//   cmd_ready  : high in IDLE (registered); accept = cmd_valid & cmd_ready
//   cmd_op     : 0 LOAD0, 1 LOAD1, 2 STEP, 3 ENABLE, 4 READ0, 5 READ1,
//                6-7 reserved (accepted as no-ops)
//   cmd_data   : write payload
//   rsp_valid  : one-cycle pulse (HOLD) when read data is captured
//   rsp_data   : last captured read data, held until the next read
//   a          : bus address
//   d_out      : bus write data
//   d_oe       : high while this block drives the data bus
//   d_in       : bus read data
//   n_we       : active-low write strobe
//   n_oe       : active-low read strobe
// ----------------------------------------------------------------------------
module stack_bus_master (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [7:0]  cmd_data,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic [15:0] a,
    output logic [7:0]  d_out,
    output logic        d_oe,
    input  logic [7:0]  d_in,
    output logic        n_we,
    output logic        n_oe
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_ready;
    logic        r_is_wr;
    logic        r_is_rd;
    logic [15:0] r_a;
    logic [7:0]  r_dout;
    logic        r_doe;
    logic        r_nwe;
    logic        r_noe;
    logic        r_rsp_valid;
    logic [7:0]  r_rsp_data;

    logic        w_accept;
    logic        w_is_wr;
    logic        w_is_rd;
    logic [15:0] w_addr;

    assign w_accept = cmd_valid && r_ready;

    // Opcode decode. Reserved opcodes are neither read nor write. They keep
    // the address at 0x0000, so nothing on the bus changes while they run.
    always_comb begin
        w_is_wr = 1'b0;
        w_is_rd = 1'b0;
        w_addr  = 16'h0000;
        case (cmd_op)
            3'd0: begin w_is_wr = 1'b1; w_addr = 16'hFC00; end
            3'd1: begin w_is_wr = 1'b1; w_addr = 16'hFC01; end
            3'd2: begin w_is_wr = 1'b1; w_addr = 16'hFC02; end
            3'd3: begin w_is_wr = 1'b1; w_addr = 16'hFC03; end
            3'd4: begin w_is_rd = 1'b1; w_addr = 16'hFC00; end
            3'd5: begin w_is_rd = 1'b1; w_addr = 16'hFC01; end
            default: begin
                w_is_wr = 1'b0;
                w_is_rd = 1'b0;
                w_addr  = 16'h0000;
            end
        endcase
    end

    // The async reset branch releases the strobes as soon as rst rises and
    // abandons any command in flight. cmd_ready is a register, so it stays
    // low through reset and comes up on the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ready     <= 1'b0;
            r_is_wr     <= 1'b0;
            r_is_rd     <= 1'b0;
            r_a         <= 16'h0000;
            r_dout      <= 8'h00;
            r_doe       <= 1'b0;
            r_nwe       <= 1'b1;
            r_noe       <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 8'h00;
        end else begin
            case (r_state)
                IDLE: begin
                    r_rsp_valid <= 1'b0;
                    r_nwe       <= 1'b1;
                    r_noe       <= 1'b1;
                    if (w_accept) begin
                        // Latch everything now; later cmd_* changes are ignored.
                        r_state <= SETUP;
                        r_ready <= 1'b0;
                        r_is_wr <= w_is_wr;
                        r_is_rd <= w_is_rd;
                        r_a     <= w_addr;
                        r_dout  <= w_is_wr ? cmd_data : 8'h00;
                        r_doe   <= w_is_wr;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    r_state <= STROBE;
                    r_nwe   <= ~r_is_wr;
                    r_noe   <= ~r_is_rd;
                end
                STROBE: begin
                    r_state <= HOLD;
                    r_nwe   <= 1'b1;
                    r_noe   <= 1'b1;
                    if (r_is_rd) begin
                        r_rsp_data  <= d_in;
                        r_rsp_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    r_state     <= IDLE;
                    r_ready     <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_a         <= 16'h0000;
                    r_dout      <= 8'h00;
                    r_doe       <= 1'b0;
                    r_is_wr     <= 1'b0;
                    r_is_rd     <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_nwe   <= 1'b1;
                    r_noe   <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign a         = r_a;
    assign d_out     = r_dout;
    assign d_oe      = r_doe;
    assign n_we      = r_nwe;
    assign n_oe      = r_noe;

endmodule

// File: tb/tb_stack_bus_master.sv
// ----------------------------------------------------------------------------
// tb_stack_bus_master
//
// Directed bench for stack_bus_master. Outputs are sampled 2 ns after each
// rising edge. Expected values are written out by hand for each step.
// ----------------------------------------------------------------------------
module tb_stack_bus_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_data;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic [15:0] a;
    logic [7:0]  d_out;
    logic        d_oe;
    logic [7:0]  d_in;
    logic        n_we;
    logic        n_oe;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  exp_rsp = 8'h00;

    stack_bus_master dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .a         (a),
        .d_out     (d_out),
        .d_oe      (d_oe),
        .d_in      (d_in),
        .n_we      (n_we),
        .n_oe      (n_oe)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Run one command from IDLE back to IDLE (4 clocks). During HOLD the
    // next command (nv/nop/ndata) is presented, so it must not be taken
    // until the following IDLE cycle.
    task automatic run_cmd(input logic [2:0] op, input logic [7:0] data,
                           input logic [7:0] din, input logic [15:0] ea,
                           input logic wr, input logic rd,
                           input logic nv, input logic [2:0] nop,
                           input logic [7:0] ndata);
        logic [7:0] ed;
        ed = wr ? data : 8'h00;
        chk("idle_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data; d_in = din;
        step(); // SETUP
        cmd_valid = 1'b0; cmd_op = 3'd6; cmd_data = ~data;
        chk("setup_ready", cmd_ready, 0);
        if (wr || rd) chk("setup_a", a, ea);
        chk("setup_nwe", n_we, 1);
        chk("setup_noe", n_oe, 1);
        chk("setup_doe", d_oe, wr);
        chk("setup_dout", d_out, ed);
        chk("setup_rspv", rsp_valid, 0);
        step(); // STROBE
        chk("strobe_ready", cmd_ready, 0);
        if (wr || rd) chk("strobe_a", a, ea);
        chk("strobe_nwe", n_we, !wr);
        chk("strobe_noe", n_oe, !rd);
        chk("strobe_doe", d_oe, wr);
        chk("strobe_dout", d_out, ed);
        chk("strobe_rspv", rsp_valid, 0);
        step(); // HOLD
        d_in = ~din;
        if (rd) exp_rsp = din;
        chk("hold_ready", cmd_ready, 0);
        if (wr || rd) chk("hold_a", a, ea);
        chk("hold_nwe", n_we, 1);
        chk("hold_noe", n_oe, 1);
        chk("hold_doe", d_oe, wr);
        chk("hold_dout", d_out, ed);
        chk("hold_rspv", rsp_valid, rd);
        chk("hold_rspd", rsp_data, exp_rsp);
        cmd_valid = nv; cmd_op = nop; cmd_data = ndata;
        step(); // IDLE
        chk("idle_a", a, 16'h0000);
        chk("idle_dout", d_out, 8'h00);
        chk("idle_doe", d_oe, 0);
        chk("idle_nwe", n_we, 1);
        chk("idle_noe", n_oe, 1);
        chk("idle_rspv", rsp_valid, 0);
        chk("idle_rspd", rsp_data, exp_rsp);
        chk("idle_ready2", cmd_ready, 1);
    endtask

    initial begin
        // Hold reset with a pending command; nothing may happen.
        rst = 1'b1; cmd_valid = 1'b1; cmd_op = 3'd0; cmd_data = 8'h5A; d_in = 8'h00;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_nwe", n_we, 1);
            chk("rst_noe", n_oe, 1);
            chk("rst_ready", cmd_ready, 0);
            chk("rst_doe", d_oe, 0);
        end
        chk("rst_a", a, 16'h0000);
        chk("rst_dout", d_out, 8'h00);
        chk("rst_rspv", rsp_valid, 0);
        chk("rst_rspd", rsp_data, 8'h00);

        rst = 1'b0; cmd_valid = 1'b0;
        #1;
        chk("rel_ready_pre", cmd_ready, 0);
        step();
        chk("rel_ready", cmd_ready, 1);
        chk("rel_nwe", n_we, 1);
        step();
        chk("rel_nwe2", n_we, 1);
        chk("rel_noe2", n_oe, 1);

        // LOAD0 0x5A
        run_cmd(3'd0, 8'h5A, 8'h00, 16'hFC00, 1, 0, 0, 3'd0, 8'h00);
        // READ1 with bus data 0xA5
        run_cmd(3'd5, 8'h00, 8'hA5, 16'hFC01, 0, 1, 0, 3'd0, 8'h00);
        // STEP 0x0E then ENABLE 0x01 back-to-back (ENABLE presented in HOLD)
        run_cmd(3'd2, 8'h0E, 8'h00, 16'hFC02, 1, 0, 1, 3'd3, 8'h01);
        run_cmd(3'd3, 8'h01, 8'h00, 16'hFC03, 1, 0, 0, 3'd0, 8'h00);

        // Reset during the STROBE of LOAD1
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_data = 8'h33; d_in = 8'h77;
        step(); // SETUP
        cmd_valid = 1'b0;
        step(); // STROBE
        chk("mid_strobe_nwe", n_we, 0);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_nwe", n_we, 1);
        chk("mid_rst_noe", n_oe, 1);
        chk("mid_rst_doe", d_oe, 0);
        chk("mid_rst_a", a, 16'h0000);
        chk("mid_rst_ready", cmd_ready, 0);
        step();
        chk("mid_rst_rspv", rsp_valid, 0);
        chk("mid_rst_rspd", rsp_data, 8'h00);
        exp_rsp = 8'h00;
        rst = 1'b0;
        step();
        chk("mid_rel_ready", cmd_ready, 1);
        chk("mid_rel_rspv", rsp_valid, 0);
        // Next command completes normally
        run_cmd(3'd4, 8'h00, 8'h3C, 16'hFC00, 0, 1, 0, 3'd0, 8'h00);

        // Reserved opcode 7: occupancy only
        run_cmd(3'd7, 8'hC3, 8'h99, 16'h0000, 0, 0, 0, 3'd0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
